// File: rtl/crem_pkg.sv
// Shared definitions for the UART command decoder: opcodes, state encoding, width defaults.
package crem_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefFunWidth  = 4;

  // Frame opcodes (first byte of every frame)
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StAOpa,
    StAOpb,
    StAFun,
    StAluWait,
    StTxLo,
    StTxHi
  } state_e;

endpackage

// File: rtl/sys_ctrl_cmd.sv
// Command decoder/sequencer between the UART and the register file / ALU.
// Parses write, read and ALU frames, drives the strobes and returns response bytes.
module sys_ctrl_cmd
  import crem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned FUN_WIDTH  = DefFunWidth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  output logic                    alu_en,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_busy,
  output logic                    cmd_drop
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    drop_q, drop_d;
  logic [DATA_WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [DATA_WIDTH-1:0]   res_hi_q, res_hi_d;
  logic                    single_q, single_d;     // response is one byte (read)
  logic                    busy_seen_q, busy_seen_d; // UART has taken the low byte

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = rd_en_q;
    alu_en_d    = alu_en_q;
    alu_fun_d   = alu_fun_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    drop_d      = 1'b0;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    single_d    = single_q;
    busy_seen_d = busy_seen_q;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data == DATA_WIDTH'(CMD_WR))           state_d = StWrAddr;
          else if (rx_data == DATA_WIDTH'(CMD_RD))      state_d = StRdAddr;
          else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  state_d = StAOpa;
          else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = StAFun;
        end
      end
      StWrAddr: begin
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = StWrData;
        end
      end
      StWrData: begin
        if (rx_valid) begin
          wr_data_d = rx_data;
          wr_en_d   = 1'b1;
          state_d   = StIdle;
        end
      end
      StRdAddr: begin
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        drop_d = rx_valid;
        if (RdData_Valid) begin
          rd_en_d  = 1'b0;
          res_lo_d = RdData;
          single_d = 1'b1;
          state_d  = StTxLo;
        end
      end
      StAOpa: begin
        if (rx_valid) begin
          addr_d    = ADDR_WIDTH'(0);
          wr_data_d = rx_data;
          wr_en_d   = 1'b1;
          state_d   = StAOpb;
        end
      end
      StAOpb: begin
        if (rx_valid) begin
          addr_d    = ADDR_WIDTH'(1);
          wr_data_d = rx_data;
          wr_en_d   = 1'b1;
          state_d   = StAFun;
        end
      end
      StAFun: begin
        if (rx_valid) begin
          alu_fun_d = rx_data[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = StAluWait;
        end
      end
      StAluWait: begin
        drop_d = rx_valid;
        if (alu_valid) begin
          alu_en_d = 1'b0;
          res_lo_d = alu_out[DATA_WIDTH-1:0];
          res_hi_d = alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
          single_d = 1'b0;
          state_d  = StTxLo;
        end
      end
      StTxLo: begin
        drop_d = rx_valid;
        if (!tx_busy) begin
          tx_valid_d  = 1'b1;
          tx_data_d   = res_lo_q;
          busy_seen_d = 1'b0;
          state_d     = single_q ? StIdle : StTxHi;
        end
      end
      StTxHi: begin
        drop_d = rx_valid;
        // Only send the high byte once the UART has visibly started on the low byte
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          tx_valid_d  = 1'b1;
          tx_data_d   = res_hi_q;
          busy_seen_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      drop_q      <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      single_q    <= 1'b0;
      busy_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      drop_q      <= drop_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      single_q    <= single_d;
      busy_seen_q <= busy_seen_d;
    end
  end

  assign WrEn     = wr_en_q;
  assign RdEn     = rd_en_q;
  assign address  = addr_q;
  assign WrData   = wr_data_q;
  assign alu_en   = alu_en_q;
  assign alu_fun  = alu_fun_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_drop = drop_q;

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Scoreboard bench for sys_ctrl_cmd: expected writes and TX bytes are queued by each
// scenario and matched by a negedge monitor when the DUT strobes them.
module tb_sys_ctrl_cmd;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          WrEn, RdEn;
  logic [AW-1:0] address;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData = '0;
  logic          RdData_Valid = 1'b0;
  logic          alu_en;
  logic [FW-1:0] alu_fun;
  logic [2*DW-1:0] alu_out = '0;
  logic          alu_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_busy;
  logic          cmd_drop;

  logic          force_busy = 1'b0;
  logic [3:0]    uart_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int drop_cnt = 0;

  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_tx[$];
  logic [AW+DW-1:0] e_wr;
  logic [DW-1:0]    e_tx;

  always #5 clk = ~clk;

  sys_ctrl_cmd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .WrEn(WrEn), .RdEn(RdEn), .address(address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_valid(alu_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy), .cmd_drop(cmd_drop)
  );

  // UART TX model: busy for a few cycles after each accepted byte
  always @(posedge clk or negedge rst) begin
    if (!rst) uart_cnt <= '0;
    else if (tx_valid) uart_cnt <= 4'd4;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 4'd1;
  end
  assign tx_busy = force_busy | (uart_cnt != 0);

  // Monitor: match strobes against the scoreboard, flag illegal overlaps
  always @(negedge clk) begin
    if (rst) begin
      if (WrEn) begin
        tests_run++;
        if (exp_wr.size() == 0) begin
          tests_failed++;
          $display("FAIL wr_unexpected: got addr=%0h data=%0h, required no write", address, WrData);
        end else begin
          e_wr = exp_wr.pop_front();
          if ({address, WrData} !== e_wr) begin
            tests_failed++;
            $display("FAIL wr_match: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     address, WrData, e_wr[AW+DW-1:DW], e_wr[DW-1:0]);
          end
        end
        if (RdEn || alu_en) begin
          tests_failed++;
          $display("FAIL strobe_overlap: got RdEn=%0b alu_en=%0b with WrEn, required 0", RdEn, alu_en);
        end
      end
      if (tx_valid) begin
        tests_run++;
        if (exp_tx.size() == 0) begin
          tests_failed++;
          $display("FAIL tx_unexpected: got %0h, required no tx", tx_data);
        end else begin
          e_tx = exp_tx.pop_front();
          if (tx_data !== e_tx) begin
            tests_failed++;
            $display("FAIL tx_match: got %0h, required %0h", tx_data, e_tx);
          end
        end
        if (force_busy) begin
          tests_failed++;
          $display("FAIL tx_while_busy: got tx_valid=1 with tx_busy=1, required 0");
        end
      end
      if (cmd_drop) drop_cnt++;
    end
  end

  task automatic send_byte(input logic [DW-1:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_tx.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    tests_run++;
    if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: got %0d writes %0d tx pending, required 0", name,
               exp_wr.size(), exp_tx.size());
      exp_wr.delete(); exp_tx.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic read_respond(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (RdEn !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    tests_run++;
    if (RdEn !== 1'b1 || address !== a) begin
      tests_failed++;
      $display("FAIL %s_rden: got RdEn=%0b addr=%0h, required 1 addr=%0h", name, RdEn, address, a);
    end
    @(negedge clk);
    tests_run++;
    if (RdEn !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_rden_hold: got %0b, required 1", name, RdEn);
    end
    @(posedge clk); #1;
    RdData = d; RdData_Valid = 1'b1;
    @(posedge clk); #1;
    RdData_Valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (RdEn !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_rden_drop: got %0b, required 0", name, RdEn);
    end
  endtask

  task automatic alu_respond(input string name, input logic [FW-1:0] f, input logic [2*DW-1:0] r);
    int n = 0;
    while (alu_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    tests_run++;
    if (alu_en !== 1'b1 || alu_fun !== f) begin
      tests_failed++;
      $display("FAIL %s_alu_en: got en=%0b fun=%0h, required 1 fun=%0h", name, alu_en, alu_fun, f);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    alu_out = r; alu_valid = 1'b1;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (alu_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_alu_drop: got %0b, required 0", name, alu_en);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({WrEn, RdEn, alu_en, tx_valid, cmd_drop} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b, required 00000", {WrEn, RdEn, alu_en, tx_valid, cmd_drop});
    end
    tests_run++;
    if ({address, WrData, alu_fun, tx_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%0h wd=%0h fun=%0h tx=%0h, required 0",
               address, WrData, alu_fun, tx_data);
    end
    @(posedge clk); #1 rst = 1'b1;
    // Abort a write frame in WR_DATA
    send_byte(8'hAA);
    send_byte(8'h05);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (address !== '0 || WrEn !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_frame: got addr=%0h WrEn=%0b, required 0 0", address, WrEn);
    end
    @(posedge clk); #1 rst = 1'b1;
    exp_tx.push_back(8'h77);
    send_byte(8'hBB);
    send_byte(8'h02);
    read_respond("reset_read", 4'h2, 8'h77);
    wait_drain("reset");
  endtask

  task automatic test_write();
    exp_wr.push_back({4'h5, 8'h3C});
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    @(negedge clk);
    tests_run++;
    if (WrEn !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_latency: got WrEn=%0b one cycle after data, required 1", WrEn);
    end
    wait_drain("write");
  endtask

  task automatic test_read();
    exp_tx.push_back(8'h3C);
    send_byte(8'hBB);
    send_byte(8'h05);
    read_respond("read", 4'h5, 8'h3C);
    wait_drain("read");
  endtask

  task automatic test_alu_op();
    exp_wr.push_back({4'h0, 8'h07});
    exp_wr.push_back({4'h1, 8'h03});
    exp_tx.push_back(8'h0A);
    exp_tx.push_back(8'h00);
    send_byte(8'hCC);
    send_byte(8'h07);
    send_byte(8'h03);
    send_byte(8'h00);
    alu_respond("alu_op", 4'h0, 16'h000A);
    wait_drain("alu_op");
  endtask

  task automatic test_alu_nop_busy();
    int early = 0;
    force_busy = 1'b1;
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'hBE);
    send_byte(8'hDD);
    send_byte(8'h02);
    alu_respond("alu_nop", 4'h2, 16'hBEEF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) early++;
    end
    tests_run++;
    if (early != 0 || exp_tx.size() != 2) begin
      tests_failed++;
      $display("FAIL busy_hold: got %0d tx while busy, required 0", early);
    end
    @(posedge clk); #1 force_busy = 1'b0;
    wait_drain("alu_nop");
  endtask

  task automatic test_ignore_drop();
    int d0;
    d0 = drop_cnt;
    exp_tx.push_back(8'h5A);
    send_byte(8'h55);
    repeat (2) @(negedge clk);
    tests_run++;
    if (drop_cnt != d0) begin
      tests_failed++;
      $display("FAIL idle_no_drop: got %0d drops, required 0", drop_cnt - d0);
    end
    send_byte(8'hBB);
    send_byte(8'h02);
    @(negedge clk);
    send_byte(8'h99);
    repeat (2) @(negedge clk);
    tests_run++;
    if (drop_cnt != d0 + 1) begin
      tests_failed++;
      $display("FAIL wait_drop: got %0d drops, required 1", drop_cnt - d0);
    end
    read_respond("drop_read", 4'h2, 8'h5A);
    wait_drain("drop");
  endtask

  task automatic test_back_to_back();
    // Stray completions in IDLE must not produce responses
    @(posedge clk); #1 RdData_Valid = 1'b1; alu_valid = 1'b1;
    @(posedge clk); #1 RdData_Valid = 1'b0; alu_valid = 1'b0;
    exp_wr.push_back({4'h3, 8'h11});
    exp_wr.push_back({4'h4, 8'h22});
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data = 8'hAA; @(posedge clk); #1;
    rx_data = 8'h13; @(posedge clk); #1;
    rx_data = 8'h11; @(posedge clk); #1;
    rx_data = 8'hAA; @(posedge clk); #1;
    rx_data = 8'hF4; @(posedge clk); #1;
    rx_data = 8'h22; @(posedge clk); #1;
    rx_valid = 1'b0;
    wait_drain("b2b");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_op();
    test_alu_nop_busy();
    test_ignore_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
